// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared types and saturating helpers for the STDP synapse array
package stdp_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } stdp_state_t;

   // Fixed-point 1.0 for a trace with frac_bits fraction bits
   function automatic longint trace_one(input int frac_bits);
      return longint'(1) << frac_bits;
   endfunction

   function automatic longint sat_add(input longint a, input longint b, input longint max_v);
      longint s;
      s = a + b;
      return (s > max_v) ? max_v : s;
   endfunction

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/stdp_trace_unit.sv
// rtl/stdp_trace_unit.sv - combinational trace decay, spike add and saturation
module stdp_trace_unit
   import stdp_pkg::*;
#(
   parameter int TRACE_WIDTH = 16,
   parameter int FRAC_BITS   = 10,
   parameter int DECAY_SHIFT = 4
) (
   input  logic [TRACE_WIDTH-1:0] trace_in,
   input  logic                   spike,
   output logic [TRACE_WIDTH-1:0] trace_out
);

   localparam longint ONE       = trace_one(FRAC_BITS);
   localparam longint TRACE_MAX = (longint'(1) << TRACE_WIDTH) - 1;

   logic [TRACE_WIDTH-1:0] dec;
   longint                 sum;

   always_comb begin
      dec       = trace_in - (trace_in >> DECAY_SHIFT);
      sum       = sat_add(longint'(dec), spike ? ONE : 64'sd0, TRACE_MAX);
      trace_out = TRACE_WIDTH'(sum);
   end

endmodule

// File: rtl/stdp_synapse_array.sv
// rtl/stdp_synapse_array.sv - shared-datapath STDP sweep engine; STDP_SOFT_BOUND_EN selects soft weight bounds
module stdp_synapse_array
   import stdp_pkg::*;
#(
   parameter int N_PRE        = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int TRACE_WIDTH  = 16,
   parameter int FRAC_BITS    = 10,
   parameter int DECAY_SHIFT  = 4,
   parameter int A_PLUS       = 5,
   parameter int A_MINUS      = 3,
   parameter int W_MAX        = 255,
   parameter int W_MIN        = 0,
   parameter int W_INIT       = 128
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            tick,
   input  logic [N_PRE-1:0]                pre_spike,
   input  logic                            post_spike,
   input  logic                            learning_enable,
   input  logic                            wr_en,
   input  logic [$clog2(N_PRE)-1:0]        wr_addr,
   input  logic [WEIGHT_WIDTH-1:0]         wr_data,
   output logic [N_PRE*WEIGHT_WIDTH-1:0]   weights_flat,
   output logic                            busy,
   output logic                            done,
   output logic                            overrun
);

   localparam int AW = $clog2(N_PRE);
   localparam int SW = WEIGHT_WIDTH + TRACE_WIDTH + 2;
   localparam int PW = TRACE_WIDTH + 32;
   localparam logic [AW-1:0] LAST_IDX = AW'(N_PRE - 1);

   stdp_state_t state, state_nxt;

   logic [AW-1:0]           idx;
   logic [N_PRE-1:0]        pre_l;
   logic                    post_l;
   logic                    learn_l;
   logic [TRACE_WIDTH-1:0]  post_trace_l;
   logic [TRACE_WIDTH-1:0]  post_trace;
   logic [WEIGHT_WIDTH-1:0] weights   [N_PRE];
   logic [TRACE_WIDTH-1:0]  pre_trace [N_PRE];
   logic                    done_r;
   logic                    overrun_r;

   logic accept, ch_wr, last_ch, host_wr, done_nxt, overrun_nxt;

   logic [WEIGHT_WIDTH-1:0] cur_w, new_w;
   logic [TRACE_WIDTH-1:0]  cur_tr, new_tr, new_post_tr;
   logic [PW-1:0]           ltp_u, ltd_u;
   logic signed [SW-1:0]    w_sum;
`ifdef STDP_SOFT_BOUND_EN
   logic [PW-1:0]           headroom, footroom;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      ch_wr       = 1'b0;
      last_ch     = 1'b0;
      host_wr     = 1'b0;
      done_nxt    = 1'b0;
      overrun_nxt = 1'b0;
      case (state)
         IDLE: begin
            host_wr = wr_en && (32'(wr_addr) < N_PRE);
            if (tick) begin
               accept    = 1'b1;
               state_nxt = SWEEP;
            end
         end
         SWEEP: begin
            ch_wr       = 1'b1;
            overrun_nxt = tick;
            if (idx == LAST_IDX) begin
               last_ch   = 1'b1;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // All operands come from registers holding the pre-tick values
   always_comb begin
      cur_w  = weights[idx];
      cur_tr = pre_trace[idx];
      ltp_u  = post_l     ? (PW'(cur_tr) * PW'(A_PLUS)) >> FRAC_BITS : '0;
      ltd_u  = pre_l[idx] ? (PW'(post_trace_l) * PW'(A_MINUS)) >> FRAC_BITS : '0;
`ifdef STDP_SOFT_BOUND_EN
      headroom = (longint'(cur_w) >= longint'(W_MAX)) ? '0
                 : PW'(longint'(W_MAX) - longint'(cur_w));
      footroom = (longint'(cur_w) <= longint'(W_MIN)) ? '0
                 : PW'(longint'(cur_w) - longint'(W_MIN));
      ltp_u    = (ltp_u * headroom) >> WEIGHT_WIDTH;
      ltd_u    = (ltd_u * footroom) >> WEIGHT_WIDTH;
`endif
      w_sum = $signed(SW'(cur_w)) + $signed(SW'(ltp_u)) - $signed(SW'(ltd_u));
      new_w = learn_l
              ? WEIGHT_WIDTH'(clamp(longint'(w_sum), longint'(W_MIN), longint'(W_MAX)))
              : cur_w;
   end

   stdp_trace_unit #(
      .TRACE_WIDTH (TRACE_WIDTH),
      .FRAC_BITS   (FRAC_BITS),
      .DECAY_SHIFT (DECAY_SHIFT)
   ) u_pre_trace (
      .trace_in  (cur_tr),
      .spike     (pre_l[idx]),
      .trace_out (new_tr)
   );

   stdp_trace_unit #(
      .TRACE_WIDTH (TRACE_WIDTH),
      .FRAC_BITS   (FRAC_BITS),
      .DECAY_SHIFT (DECAY_SHIFT)
   ) u_post_trace (
      .trace_in  (post_trace_l),
      .spike     (post_l),
      .trace_out (new_post_tr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx          <= '0;
         pre_l        <= '0;
         post_l       <= 1'b0;
         learn_l      <= 1'b0;
         post_trace_l <= '0;
         post_trace   <= '0;
         done_r       <= 1'b0;
         overrun_r    <= 1'b0;
         for (int i = 0; i < N_PRE; i++) begin
            weights[i]   <= WEIGHT_WIDTH'(W_INIT);
            pre_trace[i] <= '0;
         end
      end else begin
         done_r    <= done_nxt;
         overrun_r <= overrun_nxt;
         if (accept) begin
            pre_l        <= pre_spike;
            post_l       <= post_spike;
            learn_l      <= learning_enable;
            post_trace_l <= post_trace;
            idx          <= '0;
         end
         if (host_wr) weights[wr_addr] <= wr_data;
         if (ch_wr) begin
            weights[idx]   <= new_w;
            pre_trace[idx] <= new_tr;
            idx            <= idx + 1'b1;
         end
         if (last_ch) begin
            post_trace <= new_post_tr;
            idx        <= '0;
         end
      end
   end

   for (genvar g = 0; g < N_PRE; g++) begin : g_flat
      assign weights_flat[g*WEIGHT_WIDTH +: WEIGHT_WIDTH] = weights[g];
   end

   assign busy    = (state == SWEEP);
   assign done    = done_r;
   assign overrun = overrun_r;

endmodule

// File: tb/tb_stdp_synapse_array.sv
// tb/tb_stdp_synapse_array.sv - self-checking bench for stdp_synapse_array
module tb_stdp_synapse_array;

   localparam int N  = 8;
   localparam int WW = 8;
   localparam logic [N*WW-1:0] ALL_INIT = {N{8'h80}};

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            tick = 1'b0;
   logic [N-1:0]    pre_spike = '0;
   logic            post_spike = 1'b0;
   logic            learning_enable = 1'b0;
   logic            wr_en = 1'b0;
   logic [2:0]      wr_addr = '0;
   logic [WW-1:0]   wr_data = '0;
   logic [N*WW-1:0] weights_flat;
   logic            busy, done, overrun;

   int checks = 0;
   int errors = 0;
   int mw[N];
   int mpt[N];
   int mpost;
   logic [N*WW-1:0] exp_q[$];

   typedef struct {
      bit         rst;
      bit         wr;
      int         wr_ch;
      int         wr_val;
      logic [7:0] pre;
      bit         post;
      bit         learn;
      int         ch;
      int         w;
   } vec_t;

   vec_t tbl[12];

   always #5 clk = ~clk;

   stdp_synapse_array dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .tick            (tick),
      .pre_spike       (pre_spike),
      .post_spike      (post_spike),
      .learning_enable (learning_enable),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .weights_flat    (weights_flat),
      .busy            (busy),
      .done            (done),
      .overrun         (overrun)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic int decay_add(input int t, input bit s);
      int d;
      d = t - (t >> 4) + (s ? 1024 : 0);
      return (d > 65535) ? 65535 : d;
   endfunction

   function automatic logic [N*WW-1:0] model_vec();
      logic [N*WW-1:0] v;
      for (int i = 0; i < N; i++) v[i*WW +: WW] = 8'(mw[i]);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mw[i]  = 128;
         mpt[i] = 0;
      end
      mpost = 0;
      exp_q.delete();
   endtask

   task automatic model_tick(input logic [N-1:0] pre, input bit post, input bit learn);
      int ltp, ltd, w;
      for (int i = 0; i < N; i++) begin
         ltp = post ? (mpt[i] * 5) >> 10 : 0;
         ltd = pre[i] ? (mpost * 3) >> 10 : 0;
         if (learn) begin
            w = mw[i] + ltp - ltd;
            mw[i] = (w < 0) ? 0 : ((w > 255) ? 255 : w);
         end
      end
      for (int i = 0; i < N; i++) mpt[i] = decay_add(mpt[i], pre[i]);
      mpost = decay_add(mpost, post);
      exp_q.push_back(model_vec());
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic host_write(input int ch, input int val);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 3'(ch);
      wr_data = 8'(val);
      @(negedge clk);
      wr_en   = 1'b0;
      mw[ch]  = val;
   endtask

   task automatic wait_done_and_score(output int lat);
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("sweep_done", done, 1'b1);
      if (exp_q.size() > 0) chk("weights_scoreboard", weights_flat, exp_q.pop_front());
   endtask

   task automatic run_tick(input logic [N-1:0] pre, input bit post, input bit learn,
                           input bit immediate, output int lat);
      if (!immediate) @(negedge clk);
      tick            = 1'b1;
      pre_spike       = pre;
      post_spike      = post;
      learning_enable = learn;
      model_tick(pre, post, learn);
      @(negedge clk);
      tick = 1'b0;
      wait_done_and_score(lat);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int ndone;

      //          rst wr ch val  pre    post learn ch  w
      tbl[0]  = '{1, 0, 0, 0,   8'h04, 0,   1,    2,  128};
      tbl[1]  = '{0, 0, 0, 0,   8'h00, 1,   1,    2,  133};
      tbl[2]  = '{1, 0, 0, 0,   8'h00, 1,   1,    0,  128};
      tbl[3]  = '{0, 0, 0, 0,   8'h01, 0,   1,    0,  125};
      tbl[4]  = '{1, 1, 5, 253, 8'h20, 0,   1,    5,  253};
      tbl[5]  = '{0, 0, 0, 0,   8'h00, 1,   1,    5,  255};
      tbl[6]  = '{1, 1, 1, 1,   8'h00, 1,   1,    1,  1};
      tbl[7]  = '{0, 0, 0, 0,   8'h02, 0,   1,    1,  0};
      tbl[8]  = '{1, 0, 0, 0,   8'h04, 0,   0,    2,  128};
      tbl[9]  = '{0, 0, 0, 0,   8'h00, 1,   0,    2,  128};
      tbl[10] = '{1, 0, 0, 0,   8'h08, 1,   1,    3,  128};
      tbl[11] = '{0, 0, 0, 0,   8'h08, 1,   1,    3,  130};

      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_weights", weights_flat, ALL_INIT);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_overrun", overrun, 1'b0);
      rst_n = 1'b1;

      for (int r = 0; r < 12; r++) begin
         if (tbl[r].rst) apply_reset();
         if (tbl[r].wr) host_write(tbl[r].wr_ch, tbl[r].wr_val);
         run_tick(tbl[r].pre, tbl[r].post, tbl[r].learn, 1'b0, lat);
         chk($sformatf("tbl%0d_latency", r), lat, 9);
         chk($sformatf("tbl%0d_w%0d", r, tbl[r].ch), weights_flat[tbl[r].ch*WW +: WW], tbl[r].w);
      end

      // Back-to-back: tick accepted in the done cycle
      apply_reset();
      run_tick(8'h10, 1'b0, 1'b1, 1'b0, lat);
      run_tick(8'h00, 1'b1, 1'b1, 1'b1, lat);
      chk("b2b_latency", lat, 9);
      chk("b2b_w4", weights_flat[4*WW +: WW], 133);

      // Overrun and host write during a sweep are both dropped
      apply_reset();
      host_write(3, 200);
      @(negedge clk);
      tick = 1'b1; pre_spike = 8'h00; post_spike = 1'b1; learning_enable = 1'b1;
      model_tick(8'h00, 1'b1, 1'b1);
      @(negedge clk);
      tick = 1'b0;
      chk("busy_after_tick", busy, 1'b1);
      @(negedge clk);
      tick = 1'b1; pre_spike = 8'hFF; post_spike = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'd9;
      @(negedge clk);
      tick = 1'b0; wr_en = 1'b0;
      chk("overrun_pulse", overrun, 1'b1);
      @(negedge clk);
      chk("overrun_width", overrun, 1'b0);
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         if (done) begin
            ndone++;
            if (exp_q.size() > 0) chk("overrun_weights", weights_flat, exp_q.pop_front());
         end
         @(negedge clk);
      end
      chk("single_done", ndone, 1);
      chk("busy_idle", busy, 1'b0);
      run_tick(8'h00, 1'b1, 1'b1, 1'b0, lat);

      // Random traffic against the model
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 3) == 0) host_write($urandom_range(0, 7), $urandom_range(0, 255));
         run_tick(8'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, 1'b0, lat);
      end

      // Reset mid-sweep reverts everything at once
      @(negedge clk);
      tick = 1'b1; pre_spike = 8'hFF; post_spike = 1'b1; learning_enable = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (3) @(negedge clk);
      chk("midsweep_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midsweep_weights", weights_flat, ALL_INIT);
      chk("midsweep_busy_cleared", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      chk("midsweep_done", done, 1'b0);
      run_tick(8'h01, 1'b1, 1'b1, 1'b0, lat);
      run_tick(8'h00, 1'b1, 1'b1, 1'b0, lat);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
